lsu_mem_ctrl: RTL and testbench

//  Executes the load/store operations that the instruction decoder selects through lsu_op,

---
 rtl/lsu_mem_ctrl_pkg.sv | 47 ++++
 rtl/lsu_align.sv | 64 ++++++
 rtl/lsu_mem_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store unit: opcodes, FSM states and
// small decode helpers used by the controller and the lane formatter.
package lsu_mem_ctrl_pkg;

    // Load/store operation selected by the decoder
    typedef enum logic [2:0] {
        LSU_LB  = 3'd0,
        LSU_LH  = 3'd1,
        LSU_LW  = 3'd2,
        LSU_LBU = 3'd3,
        LSU_LHU = 3'd4,
        LSU_SB  = 3'd5,
        LSU_SH  = 3'd6,
        LSU_SW  = 3'd7
    } lsu_op_e;

    // Controller states; only one access is ever in flight
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // True for the five load opcodes
    function automatic logic op_is_load(input lsu_op_e op);
        return (op == LSU_LB) || (op == LSU_LH) || (op == LSU_LW) ||
               (op == LSU_LBU) || (op == LSU_LHU);
    endfunction

    // Halfwords need an even address, words need a multiple of four
    function automatic logic op_misaligned(input lsu_op_e op, input logic [1:0] addr_lo);
        logic bad;
        case (op)
            LSU_LH, LSU_LHU, LSU_SH: bad = addr_lo[0];
            LSU_LW, LSU_SW:          bad = |addr_lo;
            default:                 bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Exactly one of read/write must be set and it must agree with the opcode
    function automatic logic op_illegal(input lsu_op_e op, input logic rd, input logic wr);
        return (rd == wr) || (rd && !op_is_load(op)) || (wr && op_is_load(op));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane formatter: replicates store data across byte lanes with the matching
// write strobes, and extracts/extends the addressed part of a loaded word.
module lsu_align
    import lsu_mem_ctrl_pkg::*;
(
    input  lsu_op_e     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store formatting: data is replicated so every enabled lane sees its bytes
    always_comb begin
        wstrb = 4'b0000;
        wdata = 32'h0000_0000;
        case (op)
            LSU_SB: begin
                wdata = {4{st_data[7:0]}};
                wstrb = 4'b0001 << addr_lo;
            end
            LSU_SH: begin
                wdata = {2{st_data[15:0]}};
                wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            LSU_SW: begin
                wdata = st_data;
                wstrb = 4'b1111;
            end
            default: begin
                wdata = 32'h0000_0000;
                wstrb = 4'b0000;
            end
        endcase
    end

    // Load extraction: pick the addressed lane, then sign- or zero-extend
    always_comb begin
        ld_byte = 8'h00;
        ld_half = 16'h0000;
        ld_data = 32'h0000_0000;
        case (addr_lo)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (op)
            LSU_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            LSU_LBU: ld_data = {24'h000000, ld_byte};
            LSU_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
            LSU_LHU: ld_data = {16'h0000, ld_half};
            LSU_LW:  ld_data = ld_word;
            default: ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: accepts one decoded memory operation at a time,
// runs it on a word-wide request/grant/rvalid bus and returns a single
// completion pulse with the extended load value or an error flag.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int RD_W    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_read,
    input  logic            req_write,
    input  logic [2:0]      req_op,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    input  logic [RD_W-1:0] req_rd,
    output logic            mem_req,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [3:0]      mem_wstrb,
    output logic [31:0]     mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [31:0]     mem_rdata,
    output logic            resp_valid,
    output logic            resp_we,
    output logic [RD_W-1:0] resp_rd,
    output logic [31:0]     resp_data,
    output logic            resp_err
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e      state;
    lsu_state_e      state_nxt;

    lsu_op_e         op_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic [RD_W-1:0] rd_q;
    logic            err_q;
    logic [CNT_W-1:0] cnt_q;

    lsu_op_e         req_op_e;
    logic            accept;
    logic            req_bad;
    logic            in_flight;
    logic            timed_out;
    logic            op_load_q;

    logic [3:0]      al_wstrb;
    logic [31:0]     al_wdata;
    logic [31:0]     al_ld_data;

    assign req_op_e  = lsu_op_e'(req_op);
    assign accept    = (state == ST_IDLE) && req_valid;
    assign req_bad   = op_illegal(req_op_e, req_read, req_write) ||
                       op_misaligned(req_op_e, req_addr[1:0]);
    assign in_flight = (state == ST_REQ) || (state == ST_WAIT);
    assign timed_out = in_flight && (cnt_q == CNT_LAST);
    assign op_load_q = op_is_load(op_q);

    lsu_align u_align (
        .op      (op_q),
        .addr_lo (addr_q[1:0]),
        .st_data (wdata_q),
        .ld_word (rdata_q),
        .wstrb   (al_wstrb),
        .wdata   (al_wdata),
        .ld_data (al_ld_data)
    );

    // State register; reset abandons whatever access was pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request capture, error flag and load data; bad requests are flagged at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= LSU_LB;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= req_op_e;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rd_q    <= req_rd;
                err_q   <= req_bad;
                rdata_q <= 32'h0000_0000;
            end else if (timed_out) begin
                err_q   <= 1'b1;
            end
            if ((state == ST_WAIT) && mem_rvalid && !timed_out) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // Bus watchdog: cleared on accept, advances on every REQ/WAIT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (in_flight) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Next-state logic; the watchdog wins over a grant or rvalid in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt = req_bad ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                if (timed_out) begin
                    state_nxt = ST_RESP;
                end else if (mem_gnt) begin
                    state_nxt = op_load_q ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (timed_out || mem_rvalid) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs: bus fields are only non-zero while requesting, response only in RESP
    always_comb begin
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'h0000_0000;
        mem_wstrb  = 4'b0000;
        mem_wdata  = 32'h0000_0000;
        resp_valid = 1'b0;
        resp_we    = 1'b0;
        resp_rd    = '0;
        resp_data  = 32'h0000_0000;
        resp_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
            end
            ST_REQ: begin
                mem_req   = 1'b1;
                mem_we    = !op_load_q;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_wstrb = al_wstrb;
                mem_wdata = al_wdata;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rd    = rd_q;
                resp_we    = !err_q && op_load_q;
                resp_data  = (!err_q && op_load_q) ? al_ld_data : 32'h0000_0000;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl: directed vector table, randomized transactions
// against an arithmetic reference model, and hand-written timeout/reset cases.
module tb_lsu_mem_ctrl;

    localparam int TIMEOUT = 8;
    localparam int RD_W    = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_read = 1'b0;
    logic            req_write = 1'b0;
    logic [2:0]      req_op = 3'd0;
    logic [31:0]     req_addr = 32'h0;
    logic [31:0]     req_wdata = 32'h0;
    logic [RD_W-1:0] req_rd = '0;
    logic            mem_req;
    logic            mem_we;
    logic [31:0]     mem_addr;
    logic [3:0]      mem_wstrb;
    logic [31:0]     mem_wdata;
    logic            mem_gnt = 1'b0;
    logic            mem_rvalid = 1'b0;
    logic [31:0]     mem_rdata = 32'h0;
    logic            resp_valid;
    logic            resp_we;
    logic [RD_W-1:0] resp_rd;
    logic [31:0]     resp_data;
    logic            resp_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rd_en;
        logic        wr_en;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        exp_err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        logic        exp_we;
    } vec_t;

    vec_t tbl[17];

    lsu_mem_ctrl #(.TIMEOUT(TIMEOUT), .RD_W(RD_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_we    (resp_we),
        .resp_rd    (resp_rd),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Global time limit so a stuck run still ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t mkv(input logic rd_en, input logic wr_en, input logic [2:0] op,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input logic [4:0] rd,
                                 input logic exp_err, input logic [31:0] exp_addr,
                                 input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                                 input logic [31:0] exp_data, input logic exp_we);
        vec_t v;
        v.rd_en = rd_en;   v.wr_en = wr_en;   v.op = op;
        v.addr = addr;     v.wdata = wdata;   v.rdata = rdata;   v.rd = rd;
        v.exp_err = exp_err;     v.exp_addr = exp_addr;   v.exp_wstrb = exp_wstrb;
        v.exp_wdata = exp_wdata; v.exp_data = exp_data;   v.exp_we = exp_we;
        return v;
    endfunction

    // Reference model: access size, lane and extension from plain arithmetic
    function automatic vec_t refModel(input logic rd_en, input logic wr_en, input logic [2:0] op,
                                      input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [31:0] rdata, input logic [4:0] rd);
        vec_t   v;
        int     size;
        int     lo;
        bit     is_load;
        bit     is_signed;
        longint val;
        is_load   = (op <= 3'd4);
        is_signed = (op == 3'd0) || (op == 3'd1);
        case (op)
            3'd0, 3'd3, 3'd5: size = 1;
            3'd1, 3'd4, 3'd6: size = 2;
            default:          size = 4;
        endcase
        lo = int'(addr % 4);
        v.rd_en = rd_en;  v.wr_en = wr_en;  v.op = op;  v.addr = addr;
        v.wdata = wdata;  v.rdata = rdata;  v.rd = rd;
        v.exp_err = (rd_en == wr_en) || (rd_en && !is_load) || (wr_en && is_load) ||
                    ((int'(addr % 4) % size) != 0);
        v.exp_addr  = addr - 32'(lo);
        v.exp_wstrb = 4'b0000;
        v.exp_wdata = 32'h0;
        v.exp_data  = 32'h0;
        v.exp_we    = !v.exp_err && is_load;
        if (!is_load) begin
            v.exp_wstrb = 4'(((1 << size) - 1) << lo);
            if (size == 1)      v.exp_wdata = 32'((wdata % 256) * 32'h01010101);
            else if (size == 2) v.exp_wdata = 32'((wdata % 65536) * 32'h00010001);
            else                v.exp_wdata = wdata;
        end else if (v.exp_we) begin
            val = (longint'(rdata) >> (8 * lo)) % (longint'(1) << (8 * size));
            if (is_signed && val >= (longint'(1) << (8 * size - 1)))
                val = val - (longint'(1) << (8 * size));
            v.exp_data = 32'(val);
        end
        return v;
    endfunction

    // Runs one transaction cycle by cycle, acting as the memory, and checks every step
    task automatic applyStimulus(input vec_t v, input int gnt_dly, input int rv_dly, input string tag);
        bit is_load;
        is_load = (v.op <= 3'd4);
        checkOutput({tag, " req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_read  = v.rd_en;
        req_write = v.wr_en;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_rd    = v.rd;
        @(negedge clk);
        req_valid = 1'b0;
        req_read  = 1'b0;
        req_write = 1'b0;
        req_op    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_rd    = 5'($urandom);
        if (v.exp_err) begin
            checkOutput({tag, " err mem_req"}, 32'(mem_req), 32'd0);
            checkOutput({tag, " err resp_valid"}, 32'(resp_valid), 32'd1);
            checkOutput({tag, " err resp_err"}, 32'(resp_err), 32'd1);
            checkOutput({tag, " err resp_we"}, 32'(resp_we), 32'd0);
            checkOutput({tag, " err resp_data"}, resp_data, 32'd0);
        end else begin
            for (int i = 0; i < gnt_dly; i++) begin
                checkOutput({tag, " held mem_req"}, 32'(mem_req), 32'd1);
                checkOutput({tag, " early resp_valid"}, 32'(resp_valid), 32'd0);
                @(negedge clk);
            end
            checkOutput({tag, " mem_req"}, 32'(mem_req), 32'd1);
            checkOutput({tag, " mem_we"}, 32'(mem_we), 32'(!is_load));
            checkOutput({tag, " mem_addr"}, mem_addr, v.exp_addr);
            checkOutput({tag, " mem_wstrb"}, 32'(mem_wstrb), 32'(v.exp_wstrb));
            if (!is_load) checkOutput({tag, " mem_wdata"}, mem_wdata, v.exp_wdata);
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            if (is_load) begin
                for (int i = 1; i < rv_dly; i++) begin
                    checkOutput({tag, " wait mem_req"}, 32'(mem_req), 32'd0);
                    checkOutput({tag, " wait resp_valid"}, 32'(resp_valid), 32'd0);
                    @(negedge clk);
                end
                checkOutput({tag, " pre-rvalid resp_valid"}, 32'(resp_valid), 32'd0);
                mem_rvalid = 1'b1;
                mem_rdata  = v.rdata;
                @(negedge clk);
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
            checkOutput({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
            checkOutput({tag, " resp_err"}, 32'(resp_err), 32'd0);
            checkOutput({tag, " resp_we"}, 32'(resp_we), 32'(v.exp_we));
            checkOutput({tag, " resp_data"}, resp_data, v.exp_data);
            if (v.exp_we) checkOutput({tag, " resp_rd"}, 32'(resp_rd), 32'(v.rd));
        end
        @(negedge clk);
        checkOutput({tag, " pulse end resp_valid"}, 32'(resp_valid), 32'd0);
        checkOutput({tag, " back to idle"}, 32'(req_ready), 32'd1);
    endtask

    // Issues a request and returns on the first negedge after acceptance
    task automatic issueRaw(input logic rd_en, input logic wr_en, input logic [2:0] op,
                            input logic [31:0] addr, input logic [4:0] rd);
        req_valid = 1'b1;
        req_read  = rd_en;
        req_write = wr_en;
        req_op    = op;
        req_addr  = addr;
        req_wdata = 32'h0;
        req_rd    = rd;
        @(negedge clk);
        req_valid = 1'b0;
        req_read  = 1'b0;
        req_write = 1'b0;
    endtask

    initial begin
        vec_t v;
        logic [2:0]  op;
        logic        rd_en;
        logic        wr_en;
        logic [31:0] addr;

        tbl[0]  = mkv(0, 1, 3'd7, 32'h100, 32'hDEADBEEF, 32'h0,        5'd3,  0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0,        0);
        tbl[1]  = mkv(0, 1, 3'd5, 32'h103, 32'h000000A5, 32'h0,        5'd4,  0, 32'h100, 4'h8, 32'hA5A5A5A5, 32'h0,        0);
        tbl[2]  = mkv(1, 0, 3'd0, 32'h102, 32'h0,        32'h12803456, 5'd5,  0, 32'h100, 4'h0, 32'h0,        32'hFFFFFF80, 1);
        tbl[3]  = mkv(1, 0, 3'd3, 32'h102, 32'h0,        32'h12803456, 5'd6,  0, 32'h100, 4'h0, 32'h0,        32'h00000080, 1);
        tbl[4]  = mkv(1, 0, 3'd1, 32'h101, 32'h0,        32'h0,        5'd7,  1, 32'h0,   4'h0, 32'h0,        32'h0,        0);
        tbl[5]  = mkv(1, 0, 3'd2, 32'h102, 32'h0,        32'h0,        5'd8,  1, 32'h0,   4'h0, 32'h0,        32'h0,        0);
        tbl[6]  = mkv(0, 1, 3'd6, 32'h102, 32'h1234CAFE, 32'h0,        5'd9,  0, 32'h100, 4'hC, 32'hCAFECAFE, 32'h0,        0);
        tbl[7]  = mkv(1, 0, 3'd1, 32'h206, 32'h0,        32'h8001FFFF, 5'd10, 0, 32'h204, 4'h0, 32'h0,        32'hFFFF8001, 1);
        tbl[8]  = mkv(1, 0, 3'd2, 32'h300, 32'h0,        32'h13579BDF, 5'd11, 0, 32'h300, 4'h0, 32'h0,        32'h13579BDF, 1);
        tbl[9]  = mkv(1, 1, 3'd2, 32'h100, 32'h0,        32'h0,        5'd12, 1, 32'h0,   4'h0, 32'h0,        32'h0,        0);
        tbl[10] = mkv(0, 0, 3'd7, 32'h100, 32'h0,        32'h0,        5'd13, 1, 32'h0,   4'h0, 32'h0,        32'h0,        0);
        tbl[11] = mkv(1, 0, 3'd5, 32'h100, 32'h0,        32'h0,        5'd14, 1, 32'h0,   4'h0, 32'h0,        32'h0,        0);
        tbl[12] = mkv(0, 1, 3'd3, 32'h100, 32'h0,        32'h0,        5'd15, 1, 32'h0,   4'h0, 32'h0,        32'h0,        0);
        tbl[13] = mkv(0, 1, 3'd5, 32'h001, 32'hFFFFFF3C, 32'h0,        5'd16, 0, 32'h0,   4'h2, 32'h3C3C3C3C, 32'h0,        0);
        tbl[14] = mkv(1, 0, 3'd4, 32'h202, 32'h0,        32'hBEEF0000, 5'd17, 0, 32'h200, 4'h0, 32'h0,        32'h0000BEEF, 1);
        tbl[15] = mkv(1, 0, 3'd4, 32'h203, 32'h0,        32'h0,        5'd18, 1, 32'h0,   4'h0, 32'h0,        32'h0,        0);
        tbl[16] = mkv(1, 0, 3'd0, 32'h001, 32'h0,        32'h00007F00, 5'd19, 0, 32'h0,   4'h0, 32'h0,        32'h0000007F, 1);

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset mem_addr", mem_addr, 32'd0);
        checkOutput("reset mem_wstrb", 32'(mem_wstrb), 32'd0);
        checkOutput("reset mem_wdata", mem_wdata, 32'd0);
        checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset resp_we", 32'(resp_we), 32'd0);
        checkOutput("reset resp_rd", 32'(resp_rd), 32'd0);
        checkOutput("reset resp_data", resp_data, 32'd0);
        checkOutput("reset resp_err", 32'(resp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            applyStimulus(tbl[i], i % 3, 1 + (i % 2), $sformatf("vec%0d", i));
        end

        // Randomized transactions against the reference model
        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) != 0) begin
                rd_en = (op <= 3'd4);
                wr_en = !rd_en;
            end else begin
                rd_en = 1'($urandom);
                wr_en = 1'($urandom);
            end
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            v = refModel(rd_en, wr_en, op, addr, $urandom, $urandom, 5'($urandom));
            applyStimulus(v, $urandom_range(0, 3), $urandom_range(1, 3), $sformatf("rnd%0d", n));
        end

        // Load granted on the 4th cycle, rvalid never arrives: watchdog fires after 8 cycles
        issueRaw(1, 0, 3'd2, 32'h100, 5'd2);
        for (int c = 1; c <= TIMEOUT; c++) begin
            checkOutput($sformatf("tmo1 c%0d resp_valid", c), 32'(resp_valid), 32'd0);
            checkOutput($sformatf("tmo1 c%0d mem_req", c), 32'(mem_req), 32'(c <= 4));
            mem_gnt = (c == 4);
            @(negedge clk);
        end
        mem_gnt = 1'b0;
        checkOutput("tmo1 resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("tmo1 resp_err", 32'(resp_err), 32'd1);
        checkOutput("tmo1 resp_we", 32'(resp_we), 32'd0);
        checkOutput("tmo1 resp_data", resp_data, 32'd0);
        checkOutput("tmo1 mem_req", 32'(mem_req), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55AA55AA;
        @(negedge clk);
        mem_rvalid = 1'b0;
        checkOutput("tmo1 late rvalid resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("tmo1 late rvalid req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        checkOutput("tmo1 settle resp_valid", 32'(resp_valid), 32'd0);

        // Store never granted: request held for 8 cycles then dropped, late grant ignored
        issueRaw(0, 1, 3'd7, 32'h400, 5'd1);
        for (int c = 1; c <= TIMEOUT; c++) begin
            checkOutput($sformatf("tmo2 c%0d mem_req", c), 32'(mem_req), 32'd1);
            checkOutput($sformatf("tmo2 c%0d resp_valid", c), 32'(resp_valid), 32'd0);
            @(negedge clk);
        end
        checkOutput("tmo2 resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("tmo2 resp_err", 32'(resp_err), 32'd1);
        checkOutput("tmo2 mem_req", 32'(mem_req), 32'd0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        checkOutput("tmo2 late gnt resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("tmo2 late gnt mem_req", 32'(mem_req), 32'd0);
        checkOutput("tmo2 late gnt req_ready", 32'(req_ready), 32'd1);

        // Reset while waiting for load data
        issueRaw(1, 0, 3'd1, 32'h200, 5'd9);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        checkOutput("rst pre mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst pre req_ready", 32'(req_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst async req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst async mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst async resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        checkOutput("rst stray rvalid resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst stray rvalid req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        checkOutput("rst settle resp_valid", 32'(resp_valid), 32'd0);
        applyStimulus(mkv(1, 0, 3'd4, 32'h202, 32'h0, 32'hBEEF0000, 5'd21, 0, 32'h200, 4'h0, 32'h0, 32'h0000BEEF, 1),
                      0, 1, "post-reset LHU");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
